// File: rtl/display_scan_scheduler.sv
// -----------------------------------------------------------------------------
// display_scan_scheduler
//
// Timed scan scheduler for a 4-digit time-multiplexed seven-segment display.
// Each digit owns one slot of SLOT_CYCLES clocks. The first BLANK_CYCLES of a
// slot keep every anode off so the segment-data mux can settle (anti-ghosting).
// The rest of the slot drives the owning digit's anode, gated by a 4-bit PWM.
// Disabled digits are skipped in round-robin order.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset (priority over all inputs)
//   enable      1 = scanning runs, 0 = display dark and scheduler idle
//   digit_en    per-digit enable, bit i = digit i takes part in the scan
//   brightness  PWM level, 0 = off, 15 = full on
//   digit_sel   index of the digit owning the current slot (segment mux select)
//   an          active-low anode enables, registered
//   slot_tick   one-cycle pulse in the last cycle of each slot
// -----------------------------------------------------------------------------
module display_scan_scheduler #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_en,
  input  logic [3:0] brightness,
  output logic [1:0] digit_sel,
  output logic [3:0] an,
  output logic       slot_tick
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [SW-1:0] slot_cnt, slot_nx;
  logic [3:0]    pwm_cnt, pwm_nx;
  logic [1:0]    sel_nx;
  logic [3:0]    an_nx;

  // First enabled digit after cur, searching cur+1, cur+2, cur+3, cur.
  // Walking k downwards lets the nearest candidate overwrite the farther ones;
  // with no digit enabled the current index is kept.
  function automatic logic [1:0] next_digit(input logic [1:0] cur,
                                            input logic [3:0] en);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (en[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Level 15 is treated as solid on, otherwise the anode is lit while the
  // slot-relative PWM count is below the level.
  function automatic logic pwm_on(input logic [3:0] cnt,
                                  input logic [3:0] lvl);
    return (lvl == 4'hF) || (cnt < lvl);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      pwm_cnt   <= '0;
      digit_sel <= 2'd0;
      an        <= 4'b1111;
    end else begin
      state     <= state_nx;
      slot_cnt  <= slot_nx;
      pwm_cnt   <= pwm_nx;
      digit_sel <= sel_nx;
      an        <= an_nx;
    end
  end

  always_comb begin
    state_nx = state;
    slot_nx  = slot_cnt;
    pwm_nx   = pwm_cnt;
    sel_nx   = digit_sel;
    an_nx    = 4'b1111;

    if (!enable) begin
      state_nx = IDLE;
      slot_nx  = '0;
      pwm_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = BLANK;
          slot_nx  = '0;
          pwm_nx   = '0;
        end
        BLANK: begin
          slot_nx = slot_cnt + SW'(1);
          pwm_nx  = pwm_cnt + 4'd1;
          if (slot_cnt == BLANK_LAST) state_nx = ON;
        end
        ON: begin
          if (slot_cnt == SLOT_LAST) begin
            state_nx = BLANK;
            slot_nx  = '0;
            pwm_nx   = '0;
            sel_nx   = next_digit(digit_sel, digit_en);
          end else begin
            slot_nx = slot_cnt + SW'(1);
            pwm_nx  = pwm_cnt + 4'd1;
          end
        end
        default: begin
          state_nx = IDLE;
          slot_nx  = '0;
          pwm_nx   = '0;
        end
      endcase
    end

    // The anode register is loaded with the value that belongs to the next
    // slot position, so an stays aligned with slot_cnt and pwm_cnt.
    if (state_nx == ON && digit_en[sel_nx] && pwm_on(pwm_nx, brightness))
      an_nx[sel_nx] = 1'b0;
  end

  assign slot_tick = (state != IDLE) && (slot_cnt == SLOT_LAST);

endmodule

// File: tb/tb_display_scan_scheduler.sv
module tb_display_scan_scheduler;

  localparam int SLOT  = 20;
  localparam int BLANK = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit_en;
  logic [3:0] brightness;
  logic [1:0] digit_sel;
  logic [3:0] an;
  logic       slot_tick;

  int checks = 0;
  int errors = 0;

  display_scan_scheduler #(
    .SLOT_CYCLES (SLOT),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digit_en  (digit_en),
    .brightness(brightness),
    .digit_sel (digit_sel),
    .an        (an),
    .slot_tick (slot_tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Steps through the first n cycles of a slot owned by digit sel and checks
  // every output against the hand-derived slot pattern.
  task automatic part_slot(input logic [1:0] sel, input logic [3:0] den,
                           input logic [3:0] br, input int n, input string tag);
    logic [3:0] exp_an;
    for (int c = 0; c < n; c++) begin
      step();
      exp_an = 4'b1111;
      if (c >= BLANK && den[sel] && (br == 4'hF || (c % 16) < int'(br)))
        exp_an[sel] = 1'b0;
      chk($sformatf("%s_sel_c%0d", tag, c), 32'(digit_sel), 32'(sel));
      chk($sformatf("%s_an_c%0d", tag, c), 32'(an), 32'(exp_an));
      chk($sformatf("%s_tick_c%0d", tag, c), 32'(slot_tick), (c == SLOT - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic run_slot(input logic [1:0] sel, input string tag);
    part_slot(sel, digit_en, brightness, SLOT, tag);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    digit_en   = 4'b1111;
    brightness = 4'hF;
    step();
    step();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_tick", 32'(slot_tick), 32'd0);

    // Full brightness, all digits: 0,1,2,3,0
    reset  = 1'b0;
    enable = 1'b1;
    run_slot(2'd0, "all0");
    run_slot(2'd1, "all1");
    run_slot(2'd2, "all2");
    run_slot(2'd3, "all3");
    run_slot(2'd0, "all0b");

    // Digits 0 and 2 only
    digit_en = 4'b0101;
    run_slot(2'd2, "alt2");
    run_slot(2'd0, "alt0");
    run_slot(2'd2, "alt2b");

    // Single digit with PWM, then brightness 0
    digit_en   = 4'b0001;
    brightness = 4'd4;
    run_slot(2'd0, "pwm4");
    brightness = 4'd0;
    run_slot(2'd0, "pwm0");

    // Enable drop mid-ON on digit 1, then re-enable
    digit_en   = 4'b1111;
    brightness = 4'hF;
    part_slot(2'd1, 4'b1111, 4'hF, 10, "pre_dis");
    enable = 1'b0;
    step();
    chk("dis_an", 32'(an), 32'hF);
    chk("dis_sel", 32'(digit_sel), 32'd1);
    chk("dis_tick", 32'(slot_tick), 32'd0);
    step();
    chk("dis_an2", 32'(an), 32'hF);
    chk("dis_sel2", 32'(digit_sel), 32'd1);
    enable = 1'b1;
    run_slot(2'd1, "reen1");

    // Reset at slot_cnt=10 on digit 2
    part_slot(2'd2, 4'b1111, 4'hF, 11, "pre_rst");
    reset = 1'b1;
    step();
    chk("mrst_sel", 32'(digit_sel), 32'd0);
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_tick", 32'(slot_tick), 32'd0);
    step();
    chk("mrst_an2", 32'(an), 32'hF);
    reset = 1'b0;
    run_slot(2'd0, "post_rst0");

    // No digits enabled: dark, ticks continue, selection held
    digit_en = 4'b0000;
    run_slot(2'd0, "none_a");
    run_slot(2'd0, "none_b");
    digit_en = 4'b1000;
    run_slot(2'd3, "only3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
